// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: turns load/store controls into a req/ack bus transaction
// and stalls the pipeline until it completes. Optional MISALIGN_TRAP_EN traps misaligned ops.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clkIn,
  input  logic              resetn,
  input  logic              memValid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [31:0]       storeDataIn,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [31:0]       busWdata,
  output logic [3:0]        busBe,
  input  logic [31:0]       busRdata,
  input  logic              busAck,
  output logic [31:0]       loadDataOut,
  output logic              stallOut,
  output logic              busErrOut,
  output logic              misalignOut
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              ld_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [31:0]       load_data_q;
  logic              bus_err_q;

  logic              mem_op;
  logic [1:0]        off;
  logic [1:0]        off_eff;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic              we_d;
  logic [31:0]       shifted;
  logic [31:0]       ext_data;

  assign mem_op = memValid & (memRead | memWrite);
  assign off    = addrIn[1:0];

  // Request decode; misaligned half/word offsets are forced down to natural alignment.
  always_comb begin
    off_eff = off;
    be_d    = 4'b0000;
    wdata_d = storeDataIn;
    we_d    = memWrite;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{storeDataIn[7:0]}};
      end
      2'b01: begin
        off_eff = {off[1], 1'b0};
        be_d    = 4'b0011 << off_eff;
        wdata_d = {2{storeDataIn[15:0]}};
      end
      2'b10: begin
        off_eff = 2'b00;
        be_d    = 4'b1111;
      end
      default: begin
        off_eff = 2'b00;
        be_d    = 4'b0000;
        we_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    shifted  = busRdata >> {off_q, 3'b000};
    ext_data = busRdata;
    case (f3_q[1:0])
      2'b00: ext_data = f3_q[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: ext_data = f3_q[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_data = busRdata;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  logic misaligned;

  assign misaligned = ((funct3[1:0] == 2'b01) & off[0]) |
                      ((funct3[1:0] == 2'b10) & (off != 2'b00));
  assign misalignOut = misalign_q;
`else
  assign misalignOut = 1'b0;
`endif

  always_ff @(posedge clkIn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      ld_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_op) begin
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              state_q     <= StDone;
              misalign_q  <= 1'b1;
              load_data_q <= '0;
              bus_err_q   <= 1'b0;
            end else
`endif
            begin
              state_q <= StReq;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= we_d;
              addr_q  <= {addrIn[ADDR_W-1:2], 2'b00};
              wdata_q <= wdata_d;
              be_q    <= be_d;
              ld_q    <= memRead;
              f3_q    <= funct3;
              off_q   <= off_eff;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack arriving on the expiry cycle still completes the access normally.
          if (busAck) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b0;
            if (ld_q) begin
              load_data_q <= ext_data;
            end
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            state_q <= StDone;
          end else if (cnt_q == CntMax) begin
            req_q       <= 1'b0;
            load_data_q <= '0;
            bus_err_q   <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
            state_q     <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stallOut    = ((state_q == StIdle) & mem_op) | (state_q == StReq);
  assign busReq      = req_q;
  assign busWe       = we_q;
  assign busAddr     = addr_q;
  assign busWdata    = wdata_q;
  assign busBe       = be_q;
  assign loadDataOut = load_data_q;
  assign busErrOut   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;

  logic        clkIn;
  logic        resetn;
  logic        memValid;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addrIn;
  logic [31:0] storeDataIn;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic [31:0] busRdata;
  logic        busAck;
  logic [31:0] loadDataOut;
  logic        stallOut;
  logic        busErrOut;
  logic        misalignOut;

  int checks;
  int failures;

  mem_access_stage #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W        (32)
  ) dut (
    .clkIn      (clkIn),
    .resetn     (resetn),
    .memValid   (memValid),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addrIn     (addrIn),
    .storeDataIn(storeDataIn),
    .busReq     (busReq),
    .busWe      (busWe),
    .busAddr    (busAddr),
    .busWdata   (busWdata),
    .busBe      (busBe),
    .busRdata   (busRdata),
    .busAck     (busAck),
    .loadDataOut(loadDataOut),
    .stallOut   (stallOut),
    .busErrOut  (busErrOut),
    .misalignOut(misalignOut)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    memValid    = 1'b1;
    memRead     = rd;
    memWrite    = wr;
    funct3      = f3;
    addrIn      = addr;
    storeDataIn = sd;
  endtask

  task automatic retire();
    memValid = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clkIn);
  endtask

  // Bus responder: call at the negedge where the op is presented in IDLE; returns at the DONE
  // negedge with REQ-cycle and stall-cycle counts and whether bus outputs held still in REQ.
  task automatic run_op(input int ack_at, input logic [31:0] rdata,
                        output int reqc, output int stallc, output logic stable);
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    reqc   = 0;
    stallc = 0;
    stable = 1'b1;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    #1;
    if (stallOut) stallc++;
    @(posedge clkIn);
    for (int n = 1; n <= 64; n++) begin
      @(negedge clkIn);
      busAck = 1'b0;
      if (stallOut) stallc++;
      if (!busReq) break;
      reqc++;
      if (n == 1) begin
        a0 = busAddr; w0 = busWdata; b0 = busBe; we0 = busWe;
      end else if (busAddr !== a0 || busWdata !== w0 || busBe !== b0 || busWe !== we0) begin
        stable = 1'b0;
      end
      if (n == ack_at) begin
        busAck   = 1'b1;
        busRdata = rdata;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clkIn);
    checks++;
    if ({busReq, busWe, busBe, busErrOut, misalignOut, stallOut} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {busReq, busWe, busBe, busErrOut, misalignOut,
               stallOut});
    end
    checks++;
    if ({busAddr, busWdata, loadDataOut} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h want 0", busAddr, busWdata, loadDataOut);
    end
    resetn = 1'b1;
    @(negedge clkIn);
  endtask

  task automatic test_no_mem();
    memValid = 1'b1; memRead = 1'b0; memWrite = 1'b0; addrIn = 32'h100;
    #1;
    checks++;
    if (stallOut !== 1'b0) begin
      failures++; $display("FAIL nonmem_stall: got %b want 0", stallOut);
    end
    @(negedge clkIn);
    memValid = 1'b0; memRead = 1'b1;
    #1;
    checks++;
    if (stallOut !== 1'b0 || busReq !== 1'b0) begin
      failures++; $display("FAIL invalid_stall: got %b/%b want 0/0", stallOut, busReq);
    end
    retire();
  endtask

  task automatic test_lb();
    int r, s; logic st;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    run_op(1, 32'h80AA_BBCC, r, s, st);
    checks++;
    if (s !== 2 || r !== 1) begin
      failures++; $display("FAIL lb_cycles: got stall=%0d req=%0d want 2/1", s, r);
    end
    checks++;
    if (busBe !== 4'b1000 || busAddr !== 32'h1000 || busWe !== 1'b0) begin
      failures++; $display("FAIL lb_bus: got be=%b addr=%h we=%b want 1000/1000/0", busBe,
                           busAddr, busWe);
    end
    checks++;
    if (loadDataOut !== 32'hFFFF_FF80 || busErrOut !== 1'b0) begin
      failures++; $display("FAIL lb_data: got %h err=%b want ffffff80/0", loadDataOut, busErrOut);
    end
    retire();
  endtask

  task automatic test_sh();
    int r, s; logic st;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    run_op(3, 32'h0, r, s, st);
    checks++;
    if (r !== 3 || s !== 4 || st !== 1'b1) begin
      failures++; $display("FAIL sh_hold: got req=%0d stall=%0d stable=%b want 3/4/1", r, s, st);
    end
    checks++;
    if (busWe !== 1'b1 || busAddr !== 32'h2000 || busBe !== 4'b1100 ||
        busWdata !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sh_bus: got we=%b addr=%h be=%b wd=%h want 1/2000/1100/abcdabcd",
                           busWe, busAddr, busBe, busWdata);
    end
    checks++;
    if (loadDataOut !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL sh_keep_load: got %h want ffffff80", loadDataOut);
    end
    retire();
  endtask

  task automatic test_lhu();
    int r, s; logic st;
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0);
    run_op(5, 32'h0000_F00F, r, s, st);
    checks++;
    if (s !== 6 || r !== 5 || st !== 1'b1) begin
      failures++; $display("FAIL lhu_cycles: got stall=%0d req=%0d stable=%b want 6/5/1", s, r,
                           st);
    end
    checks++;
    if (loadDataOut !== 32'h0000_F00F || busBe !== 4'b0011) begin
      failures++; $display("FAIL lhu_data: got %h be=%b want 0000f00f/0011", loadDataOut, busBe);
    end
    retire();
  endtask

  task automatic test_timeout();
    int r, s; logic st;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    run_op(0, 32'h0, r, s, st);
    checks++;
    if (r !== 16 || s !== 17) begin
      failures++; $display("FAIL timeout_cycles: got req=%0d stall=%0d want 16/17", r, s);
    end
    checks++;
    if (busErrOut !== 1'b1 || loadDataOut !== 32'h0) begin
      failures++; $display("FAIL timeout_flag: got err=%b data=%h want 1/0", busErrOut,
                           loadDataOut);
    end
    retire();
    checks++;
    if (busErrOut !== 1'b1) begin
      failures++; $display("FAIL timeout_hold: got err=%b want 1", busErrOut);
    end
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0);
    run_op(16, 32'hDEAD_BEEF, r, s, st);
    checks++;
    if (r !== 16 || busErrOut !== 1'b0 || loadDataOut !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ack_at_expiry: got req=%0d err=%b data=%h want 16/0/deadbeef", r,
                           busErrOut, loadDataOut);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int r, s; logic st;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
    @(posedge clkIn);
    @(negedge clkIn);
    checks++;
    if (busReq !== 1'b1) begin
      failures++; $display("FAIL rst_mid_req: got %b want 1", busReq);
    end
    resetn = 1'b0; memValid = 1'b0; memRead = 1'b0;
    @(negedge clkIn);
    checks++;
    if (busReq !== 1'b0 || stallOut !== 1'b0 || loadDataOut !== 32'h0) begin
      failures++; $display("FAIL rst_mid_clear: got req=%b stall=%b data=%h want 0/0/0", busReq,
                           stallOut, loadDataOut);
    end
    resetn = 1'b1; busAck = 1'b1; busRdata = 32'h1111_1111;
    @(negedge clkIn);
    busAck = 1'b0;
    checks++;
    if (loadDataOut !== 32'h0 || busReq !== 1'b0 || busErrOut !== 1'b0) begin
      failures++; $display("FAIL stray_ack: got data=%h req=%b err=%b want 0/0/0", loadDataOut,
                           busReq, busErrOut);
    end
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0081, 32'h0);
    run_op(1, 32'h0000_AB00, r, s, st);
    checks++;
    if (r !== 1 || loadDataOut !== 32'h0000_00AB || busAddr !== 32'h80) begin
      failures++; $display("FAIL post_rst_op: got req=%0d data=%h addr=%h want 1/000000ab/80", r,
                           loadDataOut, busAddr);
    end
    retire();
  endtask

  task automatic test_misalign();
    int r, s; logic st;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    run_op(1, 32'hCAFE_F00D, r, s, st);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (r !== 0 || s !== 1 || misalignOut !== 1'b1 || loadDataOut !== 32'h0) begin
      failures++; $display("FAIL misalign_trap: got req=%0d stall=%0d mis=%b data=%h want 0/1/1/0",
                           r, s, misalignOut, loadDataOut);
    end
    retire();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0);
    run_op(1, 32'h1234_5678, r, s, st);
    checks++;
    if (misalignOut !== 1'b0 || loadDataOut !== 32'h1234_5678) begin
      failures++; $display("FAIL misalign_clear: got mis=%b data=%h want 0/12345678", misalignOut,
                           loadDataOut);
    end
`else
    checks++;
    if (r !== 1 || busAddr !== 32'h4 || busBe !== 4'b1111 || loadDataOut !== 32'hCAFE_F00D ||
        misalignOut !== 1'b0) begin
      failures++; $display("FAIL misalign_force: got req=%0d addr=%h be=%b data=%h mis=%b", r,
                           busAddr, busBe, loadDataOut, misalignOut);
    end
`endif
    retire();
  endtask

  task automatic test_back_to_back();
    int r, s; logic st;
    issue(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_0055);
    run_op(1, 32'h0, r, s, st);
    checks++;
    if (busBe !== 4'b0010 || busWdata !== 32'h5555_5555 || busWe !== 1'b1) begin
      failures++; $display("FAIL sb_bus: got be=%b wd=%h we=%b want 0010/55555555/1", busBe,
                           busWdata, busWe);
    end
    issue(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0);
    #1;
    checks++;
    if (stallOut !== 1'b0) begin
      failures++; $display("FAIL done_no_stall: got %b want 0", stallOut);
    end
    @(negedge clkIn);
    run_op(1, 32'h8001_0000, r, s, st);
    checks++;
    if (r !== 1 || s !== 2 || loadDataOut !== 32'hFFFF_8001) begin
      failures++; $display("FAIL lh_b2b: got req=%0d stall=%0d data=%h want 1/2/ffff8001", r, s,
                           loadDataOut);
    end
    retire();
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0; memValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    funct3 = 3'b000; addrIn = '0; storeDataIn = '0; busRdata = '0; busAck = 1'b0;
    test_reset();
    test_no_mem();
    test_lb();
    test_sh();
    test_lhu();
    test_timeout();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
